// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin front end that lets two requesters share one
// single-port RAM. Each transaction is one word. The arbiter latches the
// winning request in IDLE, presents it to the RAM for exactly one cycle,
// waits one extra cycle for read data, and then pulses the requester's ack.
module mem_rr_arbiter #(
    parameter int DW = 16,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          grant_id,
    output logic          mem_r_w,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_d_in,
    input  logic [DW-1:0] mem_d_out
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_ACK     = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic          grant_q, grant_d;
    logic          we_q, we_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          mem_r_w_q, mem_r_w_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_d_in_q, mem_d_in_d;
    logic          win_s;

    // Next-state logic: arbitration in IDLE, one-cycle RAM access, read capture.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        we_d       = we_q;
        rdata_d    = rdata_q;
        mem_addr_d = mem_addr_q;
        mem_d_in_d = mem_d_in_q;
        mem_r_w_d  = 1'b0;          // a write strobe never outlives ISSUE
        win_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    // Contention goes to the pointer; a lone request just wins.
                    if (req0 && req1) begin
                        win_s = rr_ptr_q;
                    end else begin
                        win_s = req1;
                    end
                    grant_d  = win_s;
                    rr_ptr_d = ~win_s;
                    if (win_s) begin
                        we_d       = we1;
                        mem_addr_d = addr1;
                        mem_d_in_d = wdata1;
                    end else begin
                        we_d       = we0;
                        mem_addr_d = addr0;
                        mem_d_in_d = wdata0;
                    end
                    mem_r_w_d = we_d;
                    state_d   = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                rdata_d = mem_d_out;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs are precomputed from the next state so they come straight off flops.
    always_comb begin
        ack0_d = 1'b0;
        ack1_d = 1'b0;
        if (state_d == ST_ACK) begin
            ack0_d = ~grant_d;
            ack1_d = grant_d;
        end else begin
            ack0_d = 1'b0;
            ack1_d = 1'b0;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= 1'b0;
            grant_q    <= 1'b0;
            we_q       <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
            rdata_q    <= {DW{1'b0}};
            mem_r_w_q  <= 1'b0;
            mem_addr_q <= {AW{1'b0}};
            mem_d_in_q <= {DW{1'b0}};
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            we_q       <= we_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            busy_q     <= busy_d;
            rdata_q    <= rdata_d;
            mem_r_w_q  <= mem_r_w_d;
            mem_addr_q <= mem_addr_d;
            mem_d_in_q <= mem_d_in_d;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rdata    = rdata_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;
    assign mem_r_w  = mem_r_w_q;
    assign mem_addr = mem_addr_q;
    assign mem_d_in = mem_d_in_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: behavioural RAM, scenario tasks, and a randomized
// phase checked against a reference memory plus round-robin pointer model.
module tb_mem_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [4:0]  addr0 = 5'h00, addr1 = 5'h00;
    logic [15:0] wdata0 = 16'h0000, wdata1 = 16'h0000;
    logic        ack0, ack1, busy, grant_id, mem_r_w;
    logic [15:0] rdata, mem_d_in, ram_dout;
    logic [4:0]  mem_addr;

    int errors = 0;
    int checks = 0;

    logic [15:0] ref_mem [32];
    bit          ref_valid [32];
    logic        ref_ptr = 1'b0;
    logic [15:0] ram [32];

    mem_rr_arbiter #(.DW(16), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .rdata(rdata), .busy(busy), .grant_id(grant_id),
        .mem_r_w(mem_r_w), .mem_addr(mem_addr), .mem_d_in(mem_d_in),
        .mem_d_out(ram_dout)
    );

    always #5 clk = ~clk;

    // RAM: write on r_w, registered read data one cycle after the address.
    always @(posedge clk) begin
        if (mem_r_w) ram[mem_addr] <= mem_d_in;
        ram_dout <= ram[mem_addr];
    end

    function automatic int lat_of(input logic we);
        return we ? 2 : 3;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ref_ptr = 1'b0;
    endtask

    // Drives one request from an idle arbiter; reports ack cycle, read data, write-strobe cycles.
    task automatic single_txn(input logic id, input logic we, input logic [4:0] a,
                              input logic [15:0] wd, output int lat,
                              output logic [15:0] rd, output logic [7:0] wmask);
        lat = -1; rd = 16'h0000; wmask = 8'h00;
        @(negedge clk);
        if (id == 1'b0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; end
        else begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k < 8 && mem_r_w) wmask[k] = 1'b1;
            if ((id == 1'b0 && ack0) || (id == 1'b1 && ack1)) begin
                lat = k; rd = rdata; break;
            end
        end
        if (id == 1'b0) req0 = 1'b0; else req1 = 1'b0;
        if (lat >= 0) ref_ptr = ~id;
    endtask

    // Raises both requests in the same idle cycle and records which ack came when.
    task automatic pair_run(input logic w0, input logic [4:0] a0, input logic [15:0] d0,
                            input logic w1, input logic [4:0] a1, input logic [15:0] d1,
                            output int id_f, output int id_s, output int cyc_f, output int cyc_s,
                            output logic [15:0] rd_f, output logic [15:0] rd_s);
        int n;
        n = 0; id_f = -1; id_s = -1; cyc_f = -1; cyc_s = -1; rd_f = 16'h0000; rd_s = 16'h0000;
        @(negedge clk);
        req0 = 1'b1; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = 1'b1; we1 = w1; addr1 = a1; wdata1 = d1;
        for (int k = 1; k <= 30 && n < 2; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if ((i == 0 && req0 && ack0) || (i == 1 && req1 && ack1)) begin
                    if (n == 0) begin id_f = i; cyc_f = k; rd_f = rdata; end
                    else begin id_s = i; cyc_s = k; rd_s = rdata; end
                    n++;
                    if (i == 0) req0 = 1'b0; else req1 = 1'b0;
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks += 8;
        if (ack0 !== 1'b0)      begin errors++; $display("FAIL reset_ack0 got=%b exp=0", ack0); end
        if (ack1 !== 1'b0)      begin errors++; $display("FAIL reset_ack1 got=%b exp=0", ack1); end
        if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (grant_id !== 1'b0)  begin errors++; $display("FAIL reset_grant got=%b exp=0", grant_id); end
        if (mem_r_w !== 1'b0)   begin errors++; $display("FAIL reset_rw got=%b exp=0", mem_r_w); end
        if (mem_addr !== 5'h00) begin errors++; $display("FAIL reset_addr got=%h exp=00", mem_addr); end
        if (mem_d_in !== 16'h0000) begin errors++; $display("FAIL reset_din got=%h exp=0000", mem_d_in); end
        rst = 1'b0;
        ref_ptr = 1'b0;
    endtask

    task automatic test_write_read();
        int lat; logic [15:0] rd; logic [7:0] wm;
        single_txn(1'b0, 1'b1, 5'h07, 16'hcc33, lat, rd, wm);
        ref_mem[7] = 16'hcc33; ref_valid[7] = 1'b1;
        checks += 2;
        if (lat != 2)      begin errors++; $display("FAIL wr_latency got=%0d exp=2", lat); end
        if (wm !== 8'h02)  begin errors++; $display("FAIL wr_strobe_cycles got=%b exp=00000010", wm); end
        single_txn(1'b0, 1'b0, 5'h07, 16'h0000, lat, rd, wm);
        checks += 3;
        if (lat != 3)          begin errors++; $display("FAIL rd_latency got=%0d exp=3", lat); end
        if (rd !== 16'hcc33)   begin errors++; $display("FAIL rd_data got=%h exp=cc33", rd); end
        if (wm !== 8'h00)      begin errors++; $display("FAIL rd_no_strobe got=%b exp=0", wm); end
    endtask

    task automatic test_simultaneous();
        int idf, ids, cf, cs, lat; logic [15:0] rf, rs, rd; logic [7:0] wm;
        do_reset();
        pair_run(1'b1, 5'h02, 16'h5577, 1'b1, 5'h0e, 16'h1464, idf, ids, cf, cs, rf, rs);
        ref_mem[2] = 16'h5577; ref_valid[2] = 1'b1;
        ref_mem[14] = 16'h1464; ref_valid[14] = 1'b1;
        ref_ptr = 1'b0;
        checks += 4;
        if (idf != 0) begin errors++; $display("FAIL sim_first_id got=%0d exp=0", idf); end
        if (ids != 1) begin errors++; $display("FAIL sim_second_id got=%0d exp=1", ids); end
        if (cf != 2)  begin errors++; $display("FAIL sim_first_cyc got=%0d exp=2", cf); end
        if (cs != 5)  begin errors++; $display("FAIL sim_second_cyc got=%0d exp=5", cs); end
        single_txn(1'b0, 1'b0, 5'h02, 16'h0000, lat, rd, wm);
        checks++;
        if (rd !== 16'h5577) begin errors++; $display("FAIL sim_rb02 got=%h exp=5577", rd); end
        single_txn(1'b1, 1'b0, 5'h0e, 16'h0000, lat, rd, wm);
        checks++;
        if (rd !== 16'h1464) begin errors++; $display("FAIL sim_rb0e got=%h exp=1464", rd); end
    endtask

    task automatic test_back_to_back();
        int done0, done1, total, since_ack, exp_id;
        do_reset();
        done0 = 0; done1 = 0; total = 0; since_ack = 99;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'h10; wdata0 = 16'($urandom);
        req1 = 1'b1; we1 = 1'b1; addr1 = 5'h18; wdata1 = 16'($urandom);
        for (int k = 1; k <= 100 && total < 8; k++) begin
            @(negedge clk);
            since_ack++;
            checks++;
            if (ack0 && ack1) begin errors++; $display("FAIL b2b_dual_ack cycle=%0d got=11 exp=one-hot", k); end
            if (since_ack == 1) begin
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap got busy=%b exp=0", busy); end
            end
            if (since_ack == 2 && total < 8) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL b2b_regrant got busy=%b exp=1", busy); end
            end
            if (ack0 || ack1) begin
                exp_id = total % 2;
                checks += 2;
                if (ack1 != exp_id[0]) begin errors++; $display("FAIL b2b_order n=%0d got=%0d exp=%0d", total, ack1, exp_id); end
                if (grant_id !== ack1) begin errors++; $display("FAIL b2b_grant_id got=%b exp=%b", grant_id, ack1); end
                total++;
                since_ack = 0;
                if (ack0) begin
                    ref_mem[addr0] = wdata0; ref_valid[addr0] = 1'b1;
                    done0++;
                    if (done0 == 4) req0 = 1'b0;
                    else begin addr0 = addr0 + 5'h01; wdata0 = 16'($urandom); end
                end else begin
                    ref_mem[addr1] = wdata1; ref_valid[addr1] = 1'b1;
                    done1++;
                    if (done1 == 4) req1 = 1'b0;
                    else begin addr1 = addr1 + 5'h01; wdata1 = 16'($urandom); end
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        ref_ptr = 1'b0;
        checks++;
        if (total != 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", total); end
    endtask

    task automatic test_read_during_write_req();
        int lat, a0c, a1c; logic [15:0] rd, r0; logic [7:0] wm;
        single_txn(1'b0, 1'b1, 5'h06, 16'h0abc, lat, rd, wm);
        ref_mem[6] = 16'h0abc; ref_valid[6] = 1'b1;
        a0c = -1; a1c = -1; r0 = 16'h0000;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'h06;
        for (int k = 1; k <= 30 && a1c < 0; k++) begin
            @(negedge clk);
            if (k == 2) begin req1 = 1'b1; we1 = 1'b1; addr1 = 5'h06; wdata1 = 16'h1144; end
            if (ack0 && a0c < 0) begin a0c = k; r0 = rdata; req0 = 1'b0; end
            if (ack1) begin a1c = k; req1 = 1'b0; end
        end
        req0 = 1'b0; req1 = 1'b0;
        ref_mem[6] = 16'h1144; ref_ptr = 1'b0;
        checks += 3;
        if (a0c != 3)          begin errors++; $display("FAIL rdw_read_cyc got=%0d exp=3", a0c); end
        if (r0 !== 16'h0abc)   begin errors++; $display("FAIL rdw_old_value got=%h exp=0abc", r0); end
        if (a1c != 6)          begin errors++; $display("FAIL rdw_write_cyc got=%0d exp=6", a1c); end
        single_txn(1'b0, 1'b0, 5'h06, 16'h0000, lat, rd, wm);
        checks++;
        if (rd !== 16'h1144)   begin errors++; $display("FAIL rdw_new_value got=%h exp=1144", rd); end
    endtask

    task automatic test_reset_mid();
        int lat, stray; logic [15:0] rd; logic [7:0] wm;
        single_txn(1'b0, 1'b0, 5'h07, 16'h0000, lat, rd, wm);
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'h07;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; req0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ref_ptr = 1'b0;
        checks += 4;
        if (ack0 !== 1'b0)      begin errors++; $display("FAIL rstmid_ack got=%b exp=0", ack0); end
        if (rdata !== 16'h0000) begin errors++; $display("FAIL rstmid_rdata got=%h exp=0000", rdata); end
        if (mem_r_w !== 1'b0)   begin errors++; $display("FAIL rstmid_rw got=%b exp=0", mem_r_w); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        stray = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (ack0 || ack1 || busy) stray++;
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL rstmid_stray got=%0d exp=0", stray); end
        single_txn(1'b1, 1'b0, 5'h07, 16'h0000, lat, rd, wm);
        checks += 2;
        if (lat != 3)        begin errors++; $display("FAIL rstmid_fresh_lat got=%0d exp=3", lat); end
        if (rd !== 16'hcc33) begin errors++; $display("FAIL rstmid_fresh_data got=%h exp=cc33", rd); end
    endtask

    task automatic test_drop_req();
        int lat, ac; logic [15:0] rd; logic [7:0] wm;
        single_txn(1'b1, 1'b1, 5'h1f, 16'h2f2f, lat, rd, wm);
        ref_mem[31] = 16'h2f2f; ref_valid[31] = 1'b1;
        ac = -1;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'h0a; wdata0 = 16'h7777;
        for (int k = 1; k <= 20 && ac < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin req0 = 1'b0; addr0 = 5'h1f; wdata0 = 16'hdead; end
            if (ack0) ac = k;
        end
        ref_mem[10] = 16'h7777; ref_valid[10] = 1'b1; ref_ptr = 1'b1;
        checks++;
        if (ac != 2) begin errors++; $display("FAIL drop_ack_cyc got=%0d exp=2", ac); end
        single_txn(1'b0, 1'b0, 5'h0a, 16'h0000, lat, rd, wm);
        checks++;
        if (rd !== 16'h7777) begin errors++; $display("FAIL drop_latched got=%h exp=7777", rd); end
        single_txn(1'b1, 1'b0, 5'h1f, 16'h0000, lat, rd, wm);
        checks++;
        if (rd !== 16'h2f2f) begin errors++; $display("FAIL drop_untouched got=%h exp=2f2f", rd); end
    endtask

    task automatic test_random();
        int mode, lat, idf, ids, cf, cs, ef, es, ecf, ecs;
        logic w [2]; logic [4:0] a [2]; logic [15:0] d [2]; logic [15:0] exp_rd [2];
        logic [15:0] rd, rf, rs; logic [7:0] wm;
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 2);
            for (int i = 0; i < 2; i++) begin
                a[i] = 5'($urandom);
                d[i] = 16'($urandom);
                w[i] = 1'($urandom) || !ref_valid[a[i]];
            end
            if (mode < 2) begin
                single_txn(mode[0], w[mode], a[mode], d[mode], lat, rd, wm);
                checks++;
                if (lat != lat_of(w[mode])) begin errors++; $display("FAIL rnd_single_lat it=%0d got=%0d exp=%0d", it, lat, lat_of(w[mode])); end
                if (w[mode]) begin
                    ref_mem[a[mode]] = d[mode]; ref_valid[a[mode]] = 1'b1;
                end else begin
                    checks++;
                    if (rd !== ref_mem[a[mode]]) begin errors++; $display("FAIL rnd_single_rd it=%0d got=%h exp=%h", it, rd, ref_mem[a[mode]]); end
                end
            end else begin
                ef = int'(ref_ptr); es = 1 - ef;
                ecf = lat_of(w[ef]); ecs = ecf + 1 + lat_of(w[es]);
                if (w[ef]) ref_mem[a[ef]] = d[ef]; else exp_rd[0] = ref_mem[a[ef]];
                if (w[es]) ref_mem[a[es]] = d[es]; else exp_rd[1] = ref_mem[a[es]];
                pair_run(w[0], a[0], d[0], w[1], a[1], d[1], idf, ids, cf, cs, rf, rs);
                ref_valid[a[0]] = 1'b1; ref_valid[a[1]] = 1'b1;
                ref_ptr = ~es[0];
                checks += 4;
                if (idf != ef)  begin errors++; $display("FAIL rnd_pair_first it=%0d got=%0d exp=%0d", it, idf, ef); end
                if (ids != es)  begin errors++; $display("FAIL rnd_pair_second it=%0d got=%0d exp=%0d", it, ids, es); end
                if (cf != ecf)  begin errors++; $display("FAIL rnd_pair_cyc1 it=%0d got=%0d exp=%0d", it, cf, ecf); end
                if (cs != ecs)  begin errors++; $display("FAIL rnd_pair_cyc2 it=%0d got=%0d exp=%0d", it, cs, ecs); end
                if (!w[ef]) begin
                    checks++;
                    if (rf !== exp_rd[0]) begin errors++; $display("FAIL rnd_pair_rd1 it=%0d got=%h exp=%h", it, rf, exp_rd[0]); end
                end
                if (!w[es]) begin
                    checks++;
                    if (rs !== exp_rd[1]) begin errors++; $display("FAIL rnd_pair_rd2 it=%0d got=%h exp=%h", it, rs, exp_rd[1]); end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin ref_mem[i] = 16'h0000; ref_valid[i] = 1'b0; end
        test_reset();
        test_write_read();
        test_simultaneous();
        test_back_to_back();
        test_read_during_write_req();
        test_reset_mid();
        test_drop_req();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
